axi4_lite_master_bridge: RTL and testbench

//  AXI4-Lite master: converts a simple command/response stream into AXI4-Lite

---
 rtl/axi4_lite_master_bridge.sv | 111 +++++++++++
 tb/tb_axi4_lite_master_bridge.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_master_bridge.sv
// axi4_lite_master_bridge: command/response stream to AXI4-Lite master, one transaction in flight
// Ports: aclk, aresetn (sync, active-low); cmd_* command stream in (valid/ready);
//        rsp_* response stream out (valid/ready); aw/w/b write and ar/r read master channels.
module axi4_lite_master_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [2:0] PROT = 3'b000
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [2:0]              awprot,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [2:0]              arprot,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rvalid,
  output logic                    rready
);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;
  state_t state;
  assign cmd_ready = state == IDLE;
  assign bready = state == WR_RESP;
  assign rready = state == RD_RESP;
  assign awprot = PROT;
  assign arprot = PROT;
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= IDLE;
      awaddr <= '0;
      awvalid <= 1'b0;
      wdata <= '0;
      wstrb <= '0;
      wvalid <= 1'b0;
      araddr <= '0;
      arvalid <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          if (cmd_write) begin
            awaddr <= cmd_addr;
            wdata <= cmd_wdata;
            wstrb <= cmd_wstrb;
            awvalid <= 1'b1;
            wvalid <= 1'b1;
            state <= WR_REQ;
          end else begin
            araddr <= cmd_addr;
            arvalid <= 1'b1;
            state <= RD_REQ;
          end
        end
        // AW and W complete independently; leave once neither is still pending
        WR_REQ: begin
          if (awready) awvalid <= 1'b0;
          if (wready) wvalid <= 1'b0;
          if ((!awvalid || awready) && (!wvalid || wready)) state <= WR_RESP;
        end
        WR_RESP: if (bvalid) begin
          rsp_write <= 1'b1;
          rsp_rdata <= '0;
          rsp_resp <= bresp;
          rsp_valid <= 1'b1;
          state <= RSP;
        end
        RD_REQ: if (arready) begin
          arvalid <= 1'b0;
          state <= RD_RESP;
        end
        RD_RESP: if (rvalid) begin
          rsp_write <= 1'b0;
          rsp_rdata <= rdata;
          rsp_resp <= rresp;
          rsp_valid <= 1'b1;
          state <= RSP;
        end
        RSP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_lite_master_bridge.sv
// tb_axi4_lite_master_bridge: directed and randomized-delay checks of the AXI4-Lite master bridge
module tb_axi4_lite_master_bridge;
  logic aclk, aresetn;
  logic cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0] cmd_wstrb;
  logic rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0] rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0] awprot, arprot;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;
  int n_chk = 0, n_fail = 0, prot_err = 0, aw_hi = 0, w_hi = 0, b_count = 0;
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0] bresp_v = 2'd0, rresp_v = 2'd0;
  logic [31:0] smem [16];
  logic [31:0] model [16];

  axi4_lite_master_bridge dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    for (int i = 0; i < 4; i++) if (s[i]) o[8*i+:8] = d[8*i+:8];
    return o;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // slave model: acts at negedge; *_f flags mark handshakes that occur at the next posedge
  initial begin
    int aw_c, w_c, b_c, ar_c, r_c;
    bit aw_f, w_f, b_f, ar_f, r_f, aw_g, w_g, ar_g;
    logic [31:0] sa, sd, ra;
    logic [3:0] ss;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
    {aw_f, w_f, b_f, ar_f, r_f, aw_g, w_g, ar_g} = '0;
    sa = 0; sd = 0; ra = 0; ss = 0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
        {aw_f, w_f, b_f, ar_f, r_f, aw_g, w_g, ar_g} = '0;
      end else begin
        if (b_f) bvalid = 0;
        if (r_f) rvalid = 0;
        if (aw_f) aw_g = 1;
        if (w_f) w_g = 1;
        if (ar_f) ar_g = 1;
        awready = awvalid && !aw_g && aw_c >= aw_dly;
        aw_c = awvalid ? aw_c + 1 : 0;
        wready = wvalid && !w_g && w_c >= w_dly;
        w_c = wvalid ? w_c + 1 : 0;
        if (aw_g && w_g && !bvalid) begin
          if (b_c >= b_dly) begin
            smem[sa[5:2]] = merge(smem[sa[5:2]], sd, ss);
            bvalid = 1; bresp = bresp_v; aw_g = 0; w_g = 0; b_c = 0;
          end else b_c++;
        end
        arready = arvalid && !ar_g && ar_c >= ar_dly;
        ar_c = arvalid ? ar_c + 1 : 0;
        if (ar_g && !rvalid) begin
          if (r_c >= r_dly) begin
            rvalid = 1; rdata = smem[ra[5:2]]; rresp = rresp_v; ar_g = 0; r_c = 0;
          end else r_c++;
        end
        aw_f = awvalid && awready;
        w_f = wvalid && wready;
        b_f = bvalid && bready;
        ar_f = arvalid && arready;
        r_f = rvalid && rready;
        if (aw_f) sa = awaddr;
        if (w_f) begin sd = wdata; ss = wstrb; end
        if (ar_f) ra = araddr;
        if (b_f) b_count++;
      end
    end
  end

  // protocol monitor: a valid without handshake must persist with a stable payload
  initial begin
    logic p_aw, p_w, p_ar, p_rsp;
    logic [31:0] p_awa, p_wd, p_ara, p_rd;
    logic [3:0] p_ws;
    logic [2:0] p_rs;
    p_aw = 0; p_w = 0; p_ar = 0; p_rsp = 0;
    p_awa = 0; p_wd = 0; p_ara = 0; p_rd = 0; p_ws = 0; p_rs = 0;
    forever begin
      @(posedge aclk);
      #1;
      if (awvalid) aw_hi++;
      if (wvalid) w_hi++;
      if (aresetn) begin
        if (p_aw && !awready && (!awvalid || awaddr !== p_awa)) prot_err++;
        if (p_w && !wready && (!wvalid || wdata !== p_wd || wstrb !== p_ws)) prot_err++;
        if (p_ar && !arready && (!arvalid || araddr !== p_ara)) prot_err++;
        if (p_rsp && !rsp_ready && (!rsp_valid || rsp_rdata !== p_rd || {rsp_write, rsp_resp} !== p_rs)) prot_err++;
        if (awprot !== 3'b000 || arprot !== 3'b000) prot_err++;
      end
      p_aw = aresetn && awvalid; p_w = aresetn && wvalid; p_ar = aresetn && arvalid; p_rsp = aresetn && rsp_valid;
      p_awa = awaddr; p_wd = wdata; p_ws = wstrb; p_ara = araddr; p_rd = rsp_rdata; p_rs = {rsp_write, rsp_resp};
    end
  end

  // called at a negedge; returns at a negedge with the command accepted
  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (!cmd_ready && n < 50) begin @(negedge aclk); n++; end
    chk("cmd_ready", 64'(cmd_ready), 1);
    @(posedge aclk);
    @(negedge aclk);
    cmd_valid = 0;
  endtask

  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output int lat);
    send(w, a, d, s);
    lat = 1;
    while (!rsp_valid && lat < 50) begin @(negedge aclk); lat++; end
    chk("rsp_valid", 64'(rsp_valid), 1);
  endtask

  task automatic release_rsp();
    rsp_ready = 1;
    @(posedge aclk);
    @(negedge aclk);
    rsp_ready = 0;
  endtask

  initial begin
    int lat, bc0, n;
    bit ok;
    logic [31:0] d, snap;
    logic [3:0] s;
    int idx;
    aresetn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
    for (int i = 0; i < 16; i++) begin smem[i] = 0; model[i] = 0; end
    smem[8] = 32'h12345678;
    model[8] = 32'h12345678;
    repeat (3) @(negedge aclk);
    chk("rst_ctrl", 64'({awvalid, wvalid, arvalid, bready, rready, rsp_valid, rsp_write}), 0);
    chk("rst_addr", {awaddr, araddr}, 0);
    chk("rst_data", {wdata, rsp_rdata}, 0);
    chk("rst_strb_resp", 64'({wstrb, rsp_resp}), 0);
    chk("rst_cmd_ready", 64'(cmd_ready), 1);
    aresetn = 1;
    @(negedge aclk);

    xact(1, 32'h10, 32'hDEADBEEF, 4'hF, lat);
    model[4] = 32'hDEADBEEF;
    chk("t1_lat", 64'(lat), 3);
    chk("t1_write", 64'(rsp_write), 1);
    chk("t1_resp", 64'(rsp_resp), 0);
    chk("t1_rdata", 64'(rsp_rdata), 0);
    release_rsp();

    aw_dly = 3; aw_hi = 0; w_hi = 0; bc0 = b_count;
    xact(1, 32'h14, 32'hCAFEF00D, 4'hF, lat);
    model[5] = 32'hCAFEF00D;
    chk("t2_lat", 64'(lat), 6);
    chk("t2_aw_cycles", 64'(aw_hi), 4);
    chk("t2_w_cycles", 64'(w_hi), 1);
    chk("t2_b_count", 64'(b_count - bc0), 1);
    chk("t2_resp", 64'({rsp_write, rsp_resp}), 64'h4);
    release_rsp();
    aw_dly = 0;

    ar_dly = 2; rresp_v = 2'd2;
    xact(0, 32'h20, 32'h0, 4'h0, lat);
    chk("t3_lat", 64'(lat), 5);
    chk("t3_rdata", 64'(rsp_rdata), 64'h12345678);
    chk("t3_resp", 64'(rsp_resp), 2);
    chk("t3_write", 64'(rsp_write), 0);
    release_rsp();
    ar_dly = 0; rresp_v = 2'd0;

    xact(1, 32'h18, 32'h1234ABCD, 4'h3, lat);
    model[6] = 32'h0000ABCD;
    snap = rsp_rdata;
    ok = 1;
    repeat (5) begin
      @(negedge aclk);
      if (!rsp_valid || !rsp_write || rsp_resp !== 2'd0 || rsp_rdata !== snap || cmd_ready) ok = 0;
    end
    chk("t4_stable", 64'(ok), 1);
    release_rsp();
    chk("t4_cmd_ready", 64'(cmd_ready), 1);
    chk("t4_rsp_drop", 64'(rsp_valid), 0);
    xact(0, 32'h18, 32'h0, 4'h0, lat);
    chk("t4_rdata_strb", 64'(rsp_rdata), 64'h0000ABCD);
    release_rsp();

    b_dly = 10;
    send(1, 32'h1C, 32'h55AA55AA, 4'hF);
    n = 0;
    while (!bready && n < 20) begin @(negedge aclk); n++; end
    chk("t5_wr_resp", 64'(bready), 1);
    aresetn = 0;
    @(negedge aclk);
    chk("t5_rst_ctrl", 64'({awvalid, wvalid, arvalid, bready, rready, rsp_valid}), 0);
    @(negedge aclk);
    aresetn = 1;
    b_dly = 0;
    ok = 1;
    repeat (5) begin
      @(negedge aclk);
      if (rsp_valid || !cmd_ready) ok = 0;
    end
    chk("t5_no_rsp", 64'(ok), 1);
    xact(0, 32'h10, 32'h0, 4'h0, lat);
    chk("t5_read_after_rst", 64'(rsp_rdata), 64'hDEADBEEF);
    chk("t5_read_lat", 64'(lat), 3);
    release_rsp();
    xact(0, 32'h1C, 32'h0, 4'h0, lat);
    chk("t5_dropped_write", 64'(rsp_rdata), 0);
    release_rsp();

    for (int i = 0; i < 100; i++) begin
      aw_dly = $urandom_range(3); w_dly = $urandom_range(3); b_dly = $urandom_range(3);
      ar_dly = $urandom_range(3); r_dly = $urandom_range(3);
      idx = $urandom_range(15);
      if (i % 2 == 0) begin
        d = $urandom;
        s = 4'($urandom_range(1, 15));
        model[idx] = merge(model[idx], d, s);
        xact(1, 32'(idx * 4), d, s, lat);
        chk("t6_wr_rsp", 64'({rsp_write, rsp_resp, rsp_rdata}), 64'h4_0000_0000);
      end else begin
        xact(0, 32'(idx * 4), 32'h0, 4'h0, lat);
        chk("t6_rd_rsp", 64'({rsp_write, rsp_resp, rsp_rdata}), 64'(model[idx]));
      end
      if ($urandom_range(1)) repeat ($urandom_range(1, 3)) @(negedge aclk);
      release_rsp();
    end
    chk("protocol", 64'(prot_err), 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
